// File: rtl/mem_pkg.sv
// Shared definitions for the core memory responder: FSM encoding, default width
// and the word returned for faulting or reset reads.
package mem_pkg;

    localparam int WIDTH_DEFAULT = 32;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_WAIT   = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;
    localparam logic [1:0] ST_RESP   = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = ST_IDLE,
        WAIT   = ST_WAIT,
        ACCESS = ST_ACCESS,
        RESP   = ST_RESP
    } state_e;

    localparam int unsigned FAULT_WORD = 0;

endpackage

// File: rtl/sram_dp.sv
// Dual-port block RAM: port A synchronous read/write, port B synchronous read-only.
// Both ports return the word stored before any same-edge write.
module sram_dp #(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 256,
    parameter int ADDR_BITS = 8
) (
    input  logic                 clk,
    input  logic                 we_a,
    input  logic                 re_a,
    input  logic [ADDR_BITS-1:0] addr_a,
    input  logic [WIDTH-1:0]     wdata_a,
    output logic [WIDTH-1:0]     rdata_a,
    input  logic [ADDR_BITS-1:0] addr_b,
    output logic [WIDTH-1:0]     rdata_b
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rdata_a_q;
    logic [WIDTH-1:0] rdata_b_q;

    // Nonblocking writes make both read ports see the pre-write contents.
    always_ff @(posedge clk) begin
        if (re_a) begin
            rdata_a_q <= mem[addr_a];
        end
        if (we_a) begin
            mem[addr_a] <= wdata_a;
        end
        rdata_b_q <= mem[addr_b];
    end

    assign rdata_a = rdata_a_q;
    assign rdata_b = rdata_b_q;

endmodule

// File: rtl/core_mem_responder.sv
// Memory-side responder: data request/response handshake with wait states plus a
// one-cycle-latency instruction fetch port, both backed by one dual-port RAM.
module core_mem_responder
    import mem_pkg::*;
#(
    parameter int WIDTH       = WIDTH_DEFAULT,
    parameter int DEPTH       = 256,
    parameter int ADDR_BITS   = 8,
    parameter int WAIT_STATES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             request,
    input  logic             wren,
    input  logic [WIDTH-1:0] address,
    input  logic [WIDTH-1:0] writedata,
    output logic [WIDTH-1:0] readdata,
    output logic             response,
    output logic             fault,
    input  logic [WIDTH-1:0] instr_addr,
    output logic [WIDTH-1:0] instruction
);

    localparam logic [WIDTH-1:0] DEPTH_LIMIT = WIDTH'(DEPTH);
    localparam logic [3:0]       WAIT_INIT   = 4'(WAIT_STATES);

    state_e           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] addr_q, addr_d;
    logic [WIDTH-1:0] wdata_q, wdata_d;
    logic             wren_q, wren_d;
    logic             response_q, response_d;
    logic             fault_q, fault_d;
    logic             rd_zero_q, rd_zero_d;
    logic             instr_zero_q, instr_zero_d;

    logic             addr_oor;
    logic             ram_we_a;
    logic             ram_re_a;
    logic [WIDTH-1:0] ram_rdata_a;
    logic [WIDTH-1:0] ram_rdata_b;

    assign addr_oor = (addr_q >= DEPTH_LIMIT);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wren_d       = wren_q;
        response_d   = response_q;
        fault_d      = fault_q;
        rd_zero_d    = rd_zero_q;
        ram_we_a     = 1'b0;
        ram_re_a     = 1'b0;
        instr_zero_d = (instr_addr >= DEPTH_LIMIT);

        case (state_q)
            IDLE: begin
                if (request) begin
                    addr_d  = address;
                    wren_d  = wren;
                    wdata_d = writedata;
                    cnt_d   = WAIT_INIT;
                    state_d = (WAIT_STATES > 0) ? WAIT : ACCESS;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                // Out-of-range writes are dropped; out-of-range reads yield the fault word.
                ram_we_a   = wren_q && !addr_oor;
                ram_re_a   = !wren_q && !addr_oor;
                if (!wren_q) begin
                    rd_zero_d = addr_oor;
                end
                response_d = 1'b1;
                fault_d    = addr_oor;
                state_d    = RESP;
            end
            RESP: begin
                response_d = 1'b0;
                fault_d    = 1'b0;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            addr_q       <= '0;
            wdata_q      <= '0;
            wren_q       <= 1'b0;
            response_q   <= 1'b0;
            fault_q      <= 1'b0;
            rd_zero_q    <= 1'b1;
            instr_zero_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wren_q       <= wren_d;
            response_q   <= response_d;
            fault_q      <= fault_d;
            rd_zero_q    <= rd_zero_d;
            instr_zero_q <= instr_zero_d;
        end
    end

    sram_dp #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .ADDR_BITS(ADDR_BITS)
    ) u_ram (
        .clk    (clk),
        .we_a   (ram_we_a),
        .re_a   (ram_re_a),
        .addr_a (addr_q[ADDR_BITS-1:0]),
        .wdata_a(wdata_q),
        .rdata_a(ram_rdata_a),
        .addr_b (instr_addr[ADDR_BITS-1:0]),
        .rdata_b(ram_rdata_b)
    );

    // RAM output registers carry no reset, so the zero flags supply reset and fault values.
    assign readdata    = rd_zero_q ? WIDTH'(FAULT_WORD) : ram_rdata_a;
    assign instruction = instr_zero_q ? WIDTH'(FAULT_WORD) : ram_rdata_b;
    assign response    = response_q;
    assign fault       = fault_q;

endmodule

// File: tb/tb_core_mem_responder.sv
// Directed bench for core_mem_responder: three instances with WAIT_STATES 2, 0 and 3
// share clock and reset and are exercised one at a time.
module tb_core_mem_responder;

    logic        clk;
    logic        rst;
    logic        request    [3];
    logic        wren       [3];
    logic [31:0] address    [3];
    logic [31:0] writedata  [3];
    logic [31:0] readdata   [3];
    logic        response   [3];
    logic        fault      [3];
    logic [31:0] instrAddr  [3];
    logic [31:0] instruction[3];

    int checks = 0;
    int errors = 0;

    function automatic int wsOf(input int idx);
        return (idx == 0) ? 2 : ((idx == 1) ? 0 : 3);
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        core_mem_responder #(
            .WIDTH      (32),
            .DEPTH      (256),
            .ADDR_BITS  (8),
            .WAIT_STATES((g == 0) ? 2 : ((g == 1) ? 0 : 3))
        ) dut (
            .clk        (clk),
            .rst        (rst),
            .request    (request[g]),
            .wren       (wren[g]),
            .address    (address[g]),
            .writedata  (writedata[g]),
            .readdata   (readdata[g]),
            .response   (response[g]),
            .fault      (fault[g]),
            .instr_addr (instrAddr[g]),
            .instruction(instruction[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    // One full access; latency counted from the sampling edge E0 to the edge raising response.
    task automatic applyStimulus(input int idx, input bit wr, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [31:0] expRd,
                                 input bit expFault, input bit holdThroughResp,
                                 output logic [31:0] instrAtResp, output logic [31:0] instrAfter);
        int n;
        @(negedge clk);
        request[idx]   = 1'b1;
        wren[idx]      = wr;
        address[idx]   = addr;
        writedata[idx] = wdata;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!response[idx] && n < 50);
        checkOutput($sformatf("latency i%0d a%0d", idx, addr), 32'(n - 1), 32'(wsOf(idx) + 1));
        checkOutput($sformatf("fault i%0d a%0d", idx, addr), 32'(fault[idx]), 32'(expFault));
        checkOutput($sformatf("readdata i%0d a%0d", idx, addr), readdata[idx], expRd);
        instrAtResp = instruction[idx];
        if (!holdThroughResp) request[idx] = 1'b0;
        @(negedge clk);
        checkOutput($sformatf("resp_pulse i%0d", idx), 32'(response[idx]), 32'd0);
        instrAfter = instruction[idx];
        if (holdThroughResp) request[idx] = 1'b0;
    endtask

    task automatic countPulses(input int idx, input int cycles, output int pulses);
        pulses = 0;
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            if (response[idx]) pulses++;
        end
    endtask

    initial begin
        logic [31:0] iA, iB;
        int pulses;
        int n;

        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            request[i] = 1'b0; wren[i] = 1'b0; address[i] = '0;
            writedata[i] = '0; instrAddr[i] = '0;
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("reset response i%0d", i), 32'(response[i]), 32'd0);
            checkOutput($sformatf("reset fault i%0d", i), 32'(fault[i]), 32'd0);
            checkOutput($sformatf("reset readdata i%0d", i), readdata[i], 32'd0);
        end

        // Instance 0 (two wait states): known contents, then reset during WAIT.
        applyStimulus(0, 1, 32'd5, 32'h0, 32'h0, 0, 0, iA, iB);
        applyStimulus(0, 1, 32'd9, 32'h0, 32'h0, 0, 0, iA, iB);
        applyStimulus(0, 1, 32'd1, 32'h11111111, 32'h0, 0, 0, iA, iB);
        applyStimulus(0, 1, 32'd2, 32'h22222222, 32'h0, 0, 0, iA, iB);

        @(negedge clk);
        request[0] = 1'b1; wren[0] = 1'b1; address[0] = 32'd5; writedata[0] = 32'hDEADBEEF;
        @(negedge clk);
        rst = 1'b1;
        request[0] = 1'b0;
        @(negedge clk);
        checkOutput("reset mid-write response", 32'(response[0]), 32'd0);
        rst = 1'b0;
        countPulses(0, 6, pulses);
        checkOutput("reset mid-write no pulse", 32'(pulses), 32'd0);
        checkOutput("reset mid-write readdata", readdata[0], 32'd0);
        applyStimulus(0, 0, 32'd5, 32'h0, 32'h0, 0, 0, iA, iB);

        // Collision: fetch of word 9 alongside a data write to word 9.
        instrAddr[0] = 32'd9;
        @(negedge clk);
        checkOutput("instr pre-collision", instruction[0], 32'h0);
        applyStimulus(0, 1, 32'd9, 32'hCAFEF00D, 32'h0, 0, 0, iA, iB);
        checkOutput("instr on access edge", iA, 32'h0);
        checkOutput("instr after access edge", iB, 32'hCAFEF00D);

        // Back-to-back reads with request held continuously.
        @(negedge clk);
        request[0] = 1'b1; wren[0] = 1'b0; address[0] = 32'd1;
        n = 0;
        do begin @(negedge clk); n++; end while (!response[0] && n < 50);
        checkOutput("b2b first latency", 32'(n - 1), 32'd3);
        checkOutput("b2b first readdata", readdata[0], 32'h11111111);
        address[0] = 32'd2;
        n = 0;
        do begin @(negedge clk); n++; end while (!response[0] && n < 50);
        request[0] = 1'b0;
        checkOutput("b2b spacing", 32'(n), 32'd5);
        checkOutput("b2b second readdata", readdata[0], 32'h22222222);
        repeat (2) @(negedge clk);

        // Instance 1 (no wait states): write/read and out-of-range behaviour.
        applyStimulus(1, 1, 32'd3, 32'h12345678, 32'h0, 0, 0, iA, iB);
        applyStimulus(1, 0, 32'd3, 32'h0, 32'h12345678, 0, 0, iA, iB);
        applyStimulus(1, 1, 32'd44, 32'h0, 32'h12345678, 0, 0, iA, iB);
        applyStimulus(1, 1, 32'd300, 32'hAAAA5555, 32'h12345678, 1, 0, iA, iB);
        applyStimulus(1, 0, 32'd300, 32'h0, 32'h0, 1, 0, iA, iB);
        applyStimulus(1, 0, 32'd44, 32'h0, 32'h0, 0, 0, iA, iB);
        applyStimulus(1, 1, 32'd44, 32'h00000044, 32'h0, 0, 0, iA, iB);
        @(negedge clk);
        instrAddr[1] = 32'd300;
        @(negedge clk);
        checkOutput("instr out of range", instruction[1], 32'h0);
        instrAddr[1] = 32'd44;
        @(negedge clk);
        checkOutput("instr word 44", instruction[1], 32'h00000044);

        // Instance 2 (three wait states): request held through RESP starts nothing new.
        applyStimulus(2, 1, 32'd7, 32'h00000077, 32'h0, 0, 0, iA, iB);
        applyStimulus(2, 0, 32'd7, 32'h0, 32'h00000077, 0, 1, iA, iB);
        countPulses(2, 10, pulses);
        checkOutput("no second access", 32'(pulses), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
